butterfly_sched: RTL and testbench
==================================

BUTTERFLY_SCHED -- requirements
Module: butterfly_sched

Interface
REQ-001 SHALL have parameter N_LOG2, default 3, meaning log2 of FFT points (N = 2^N_LOG2, range 2..10).
REQ-002 SHALL have parameter PIPE_LAT, default 2, meaning cycles from rd_en to the matching wr_en (memory read plus butterfly pipeline), range 1..8.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to run a full N-point transform.
REQ-006 SHALL have port mode  input  1  sampled with start; 0 = DIT, 1 = DIF.
REQ-007 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse after the final write.
REQ-009 SHALL have port rd_en  output  1  butterfly operand read strobe.
REQ-010 SHALL have ports rd_addr_a and rd_addr_b  output  N_LOG2  operand addresses.
REQ-011 SHALL have port tw_idx  output  N_LOG2-1  twiddle ROM index, aligned with rd_en.
REQ-012 SHALL have port bf_s  output  1  butterfly select, equal to the latched mode, aligned with rd_en.
REQ-013 SHALL have port wr_en  output  1  result write strobe.
REQ-014 SHALL have ports wr_addr_a and wr_addr_b  output  N_LOG2  result addresses (outa to a, outb to b).

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, and FIN.
REQ-016 SHALL move from IDLE to RUN on start; in RUN, mode SHALL be latched, stage counter s = 0, and butterfly counter k = 0.
REQ-017 SHALL, in RUN, assert rd_en every cycle and increment k from 0 to N/2-1, for exactly N/2 rd_en cycles per stage.
REQ-018 SHALL move from RUN to DRAIN after k = N/2-1; DRAIN SHALL last exactly PIPE_LAT cycles with rd_en low, which prevents read-after-write hazards between stages.
REQ-019 SHALL, at the end of DRAIN, move to RUN with s+1 and k = 0 if s < N_LOG2-1; otherwise it SHALL move to FIN.
REQ-020 SHALL, in FIN, pulse done for one cycle, deassert busy, and return to IDLE.
REQ-021 SHALL use span = 2^s for DIT and span = 2^(N_LOG2-1-s) for DIF.
REQ-022 SHALL compute pos = k mod span, grp = k / span, rd_addr_a = 2*span*grp + pos, rd_addr_b = rd_addr_a + span, and tw_idx = pos * (N/(2*span)), with all arithmetic unsigned and modulo 2^N_LOG2.
REQ-023 SHALL produce wr_en, wr_addr_a, and wr_addr_b as rd_en, rd_addr_a, and rd_addr_b delayed by exactly PIPE_LAT cycles through a shift register.
REQ-024 SHALL give a transform a total length of N_LOG2*(N/2+PIPE_LAT) cycles in RUN plus DRAIN, with done in the following cycle.
REQ-025 SHALL ignore start while busy, with no restart and no mode change.
REQ-026 SHALL keep rd_addr_*, wr_addr_*, and tw_idx at 0 whenever their strobe is low.
REQ-027 SHALL allow start in the same cycle as done; this start SHALL be ignored, and start is accepted only in IDLE.

Reset
REQ-028 SHALL, on rst low, immediately force state IDLE, with busy, done, rd_en, wr_en, bf_s, all addresses, tw_idx, and counters at 0, and the write shift register cleared.
REQ-029 SHALL discard in-flight writes on reset mid-transform, with no wr_en after rst deasserts.
REQ-030 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-031 SHALL, when macro BFSCHED_ABORT_EN is defined, add port abort  input  1; abort high in RUN or DRAIN SHALL force IDLE on the next edge, clear the write shift register, keep wr_en low thereafter, and not pulse done.
REQ-032 SHALL, when BFSCHED_ABORT_EN is undefined, have no abort port and SHALL complete every accepted transform.

Verification
REQ-033 SHALL test DIT with N_LOG2=3 and PIPE_LAT=2 by pulsing start with mode=0; the required response is stage 0 pairs (0,1),(2,3),(4,5),(6,7) with tw 0,0,0,0; stage 1 pairs (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2; stage 2 pairs (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3; and done 18 cycles after busy rises.
REQ-034 SHALL test DIF by pulsing start with mode=1; the required response is stage 0 pairs (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3, stage 2 pairs (0,1),(2,3),… with tw 0, and bf_s=1 throughout.
REQ-035 SHALL test write alignment; every wr_en SHALL occur exactly 2 cycles after its rd_en with identical addresses, and there SHALL be no rd_en in the 2 DRAIN cycles of each stage.
REQ-036 SHALL test start while busy by re-pulsing start with mode flipped mid-stage 1; the required response is an unchanged sequence and bf_s, and a single done.
REQ-037 SHALL test reset mid-run by driving rst low for 3 cycles during stage 1; the required response is all outputs at 0 immediately, no wr_en afterwards, and a new start giving a clean 18-cycle run.
REQ-038 SHALL test abort with BFSCHED_ABORT_EN defined by pulsing abort during DRAIN of stage 0; the required response is IDLE on the next cycle, busy low, no further wr_en, and no done.

Source files
------------

// File: rtl/butterfly_sched_if.sv
// Butterfly scheduler bus: start/mode request, status, operand read and result write strobes.
// When BFSCHED_ABORT_EN is defined the bus also carries the abort request.
interface butterfly_sched_if #(
   parameter int N_LOG2 = 3
);
   logic              start;
   logic              mode;
   logic              busy;
   logic              done;
   logic              rd_en;
   logic [N_LOG2-1:0] rd_addr_a;
   logic [N_LOG2-1:0] rd_addr_b;
   logic [N_LOG2-2:0] tw_idx;
   logic              bf_s;
   logic              wr_en;
   logic [N_LOG2-1:0] wr_addr_a;
   logic [N_LOG2-1:0] wr_addr_b;
`ifdef BFSCHED_ABORT_EN
   logic              abort;

   modport master (
      output start, mode, abort,
      input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx, bf_s,
             wr_en, wr_addr_a, wr_addr_b
   );

   modport slave (
      input  start, mode, abort,
      output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx, bf_s,
             wr_en, wr_addr_a, wr_addr_b
   );
`else
   modport master (
      output start, mode,
      input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx, bf_s,
             wr_en, wr_addr_a, wr_addr_b
   );

   modport slave (
      input  start, mode,
      output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx, bf_s,
             wr_en, wr_addr_a, wr_addr_b
   );
`endif
endinterface

// File: rtl/butterfly_sched.sv
// In-place radix-2 FFT butterfly address scheduler (DIT or DIF).
// Walks N_LOG2 stages of N/2 butterflies, then PIPE_LAT idle cycles per stage so
// that every write of a stage lands before the next stage reads.  Write strobes and
// addresses are the read ones delayed by PIPE_LAT cycles.
// Optional macro BFSCHED_ABORT_EN adds an abort request on the bus.
module butterfly_sched #(
   parameter int N_LOG2   = 3,
   parameter int PIPE_LAT = 2
)(
   input  logic             clk,
   input  logic             rst,
   butterfly_sched_if.slave bus
);
   localparam int AW = N_LOG2;
   localparam int KW = N_LOG2 - 1;
   localparam int SW = $clog2(N_LOG2);
   localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
   localparam logic [KW-1:0] K_ZERO = {KW{1'b0}};
   localparam logic [KW-1:0] K_ONE  = {{(KW-1){1'b0}}, 1'b1};
   localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);
   localparam logic [SW-1:0] S_ZERO = {SW{1'b0}};
   localparam logic [SW-1:0] S_ONE  = {{(SW-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);
   localparam logic [DW-1:0] D_ZERO = {DW{1'b0}};
   localparam logic [DW-1:0] D_ONE  = {{(DW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] A_ZERO = {AW{1'b0}};
   localparam logic [AW-1:0] A_ONE  = {{(AW-1){1'b0}}, 1'b1};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_FIN   = 2'd3;

   logic [1:0]    state_r, nxt_state_s;
   logic [SW-1:0] s_cnt_r, nxt_s_s;
   logic [KW-1:0] k_cnt_r, nxt_k_s;
   logic [DW-1:0] d_cnt_r, nxt_d_s;
   logic          mode_r, nxt_mode_s;
   logic          flush_s;

   logic [SW-1:0] sh_s;
   logic [AW-1:0] span_s, k_ext_s, pos_s, grp_s, addr_a_s, addr_b_s;
   logic [KW-1:0] tw_s;

   logic          busy_r, done_r, rd_en_r, bf_s_r;
   logic [AW-1:0] rd_a_r, rd_b_r;
   logic [KW-1:0] tw_r;

   logic          pipe_en_r [PIPE_LAT];
   logic [AW-1:0] pipe_a_r  [PIPE_LAT];
   logic [AW-1:0] pipe_b_r  [PIPE_LAT];

   // Next-state and counter update; an abort (when built in) overrides everything.
   always_comb begin
      nxt_state_s = state_r;
      nxt_s_s     = s_cnt_r;
      nxt_k_s     = k_cnt_r;
      nxt_d_s     = d_cnt_r;
      nxt_mode_s  = mode_r;
      flush_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               nxt_state_s = ST_RUN;
               nxt_mode_s  = bus.mode;
               nxt_s_s     = S_ZERO;
               nxt_k_s     = K_ZERO;
               nxt_d_s     = D_ZERO;
            end else begin
               nxt_state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (k_cnt_r == K_LAST) begin
               nxt_state_s = ST_DRAIN;
               nxt_k_s     = K_ZERO;
               nxt_d_s     = D_ZERO;
            end else begin
               nxt_k_s     = k_cnt_r + K_ONE;
            end
         end
         ST_DRAIN: begin
            if (d_cnt_r == D_LAST) begin
               nxt_d_s = D_ZERO;
               if (s_cnt_r == S_LAST) begin
                  nxt_state_s = ST_FIN;
               end else begin
                  nxt_state_s = ST_RUN;
                  nxt_s_s     = s_cnt_r + S_ONE;
                  nxt_k_s     = K_ZERO;
               end
            end else begin
               nxt_d_s = d_cnt_r + D_ONE;
            end
         end
         ST_FIN: begin
            nxt_state_s = ST_IDLE;
            nxt_s_s     = S_ZERO;
            nxt_k_s     = K_ZERO;
            nxt_d_s     = D_ZERO;
         end
         default: begin
            nxt_state_s = ST_IDLE;
            nxt_s_s     = S_ZERO;
            nxt_k_s     = K_ZERO;
            nxt_d_s     = D_ZERO;
         end
      endcase
`ifdef BFSCHED_ABORT_EN
      if (bus.abort && ((state_r == ST_RUN) || (state_r == ST_DRAIN))) begin
         nxt_state_s = ST_IDLE;
         nxt_s_s     = S_ZERO;
         nxt_k_s     = K_ZERO;
         nxt_d_s     = D_ZERO;
         flush_s     = 1'b1;
      end else begin
         flush_s     = 1'b0;
      end
`endif
   end

   // Operand addresses and twiddle index for the butterfly issued next cycle.
   always_comb begin
      sh_s     = nxt_mode_s ? (S_LAST - nxt_s_s) : nxt_s_s;
      span_s   = A_ONE << sh_s;
      k_ext_s  = {1'b0, nxt_k_s};
      pos_s    = k_ext_s & (span_s - A_ONE);
      grp_s    = k_ext_s >> sh_s;
      addr_a_s = ((grp_s << sh_s) << 1'b1) | pos_s;
      addr_b_s = addr_a_s + span_s;
      // pos < span <= N/2, so it always fits the twiddle index width
      tw_s     = pos_s[KW-1:0] << (S_LAST - sh_s);
   end

   // FSM state, stage/butterfly/drain counters and latched mode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         s_cnt_r <= S_ZERO;
         k_cnt_r <= K_ZERO;
         d_cnt_r <= D_ZERO;
         mode_r  <= 1'b0;
      end else begin
         state_r <= nxt_state_s;
         s_cnt_r <= nxt_s_s;
         k_cnt_r <= nxt_k_s;
         d_cnt_r <= nxt_d_s;
         mode_r  <= nxt_mode_s;
      end
   end

   // Registered status and read-side outputs; addresses held at zero without a strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         rd_en_r <= 1'b0;
         bf_s_r  <= 1'b0;
         rd_a_r  <= A_ZERO;
         rd_b_r  <= A_ZERO;
         tw_r    <= K_ZERO;
      end else begin
         busy_r  <= (nxt_state_s == ST_RUN) || (nxt_state_s == ST_DRAIN);
         done_r  <= (nxt_state_s == ST_FIN);
         rd_en_r <= (nxt_state_s == ST_RUN);
         bf_s_r  <= ((nxt_state_s == ST_RUN) || (nxt_state_s == ST_DRAIN)) ? nxt_mode_s : 1'b0;
         if (nxt_state_s == ST_RUN) begin
            rd_a_r <= addr_a_s;
            rd_b_r <= addr_b_s;
            tw_r   <= tw_s;
         end else begin
            rd_a_r <= A_ZERO;
            rd_b_r <= A_ZERO;
            tw_r   <= K_ZERO;
         end
      end
   end

   // Write-side delay line: the last stage is the write strobe/addresses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            pipe_en_r[i] <= 1'b0;
            pipe_a_r[i]  <= A_ZERO;
            pipe_b_r[i]  <= A_ZERO;
         end
      end else if (flush_s) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            pipe_en_r[i] <= 1'b0;
            pipe_a_r[i]  <= A_ZERO;
            pipe_b_r[i]  <= A_ZERO;
         end
      end else begin
         pipe_en_r[0] <= rd_en_r;
         pipe_a_r[0]  <= rd_a_r;
         pipe_b_r[0]  <= rd_b_r;
         for (int i = 1; i < PIPE_LAT; i++) begin
            pipe_en_r[i] <= pipe_en_r[i-1];
            pipe_a_r[i]  <= pipe_a_r[i-1];
            pipe_b_r[i]  <= pipe_b_r[i-1];
         end
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.rd_en     = rd_en_r;
   assign bus.rd_addr_a = rd_a_r;
   assign bus.rd_addr_b = rd_b_r;
   assign bus.tw_idx    = tw_r;
   assign bus.bf_s      = bf_s_r;
   assign bus.wr_en     = pipe_en_r[PIPE_LAT-1];
   assign bus.wr_addr_a = pipe_a_r[PIPE_LAT-1];
   assign bus.wr_addr_b = pipe_b_r[PIPE_LAT-1];
endmodule

// File: tb/tb_butterfly_sched.sv
// Self-checking bench for butterfly_sched (N_LOG2=3, PIPE_LAT=2).
// Expected butterfly pairs/twiddles come from a hand-filled table; a cycle model
// derives rd/wr/busy/done timing from it.  Abort test needs BFSCHED_ABORT_EN.
module tb_butterfly_sched;
   localparam int N_LOG2   = 3;
   localparam int PIPE_LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;

   // 100 MHz-style free-running clock.
   always #5 clk = ~clk;

   butterfly_sched_if #(.N_LOG2(N_LOG2)) bus ();

   butterfly_sched #(.N_LOG2(N_LOG2), .PIPE_LAT(PIPE_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       mode;
      logic [2:0] a;
      logic [2:0] b;
      logic [1:0] tw;
   } vec_t;

   vec_t tab [24];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic m, input int a, input int b, input int tw);
      tab[i].mode = m;
      tab[i].a    = 3'(a);
      tab[i].b    = 3'(b);
      tab[i].tw   = 2'(tw);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " busy"},  bus.busy,      0);
      check({tag, " done"},  bus.done,      0);
      check({tag, " rd_en"}, bus.rd_en,     0);
      check({tag, " wr_en"}, bus.wr_en,     0);
      check({tag, " bf_s"},  bus.bf_s,      0);
      check({tag, " rd_a"},  bus.rd_addr_a, 0);
      check({tag, " rd_b"},  bus.rd_addr_b, 0);
      check({tag, " tw"},    bus.tw_idx,    0);
      check({tag, " wr_a"},  bus.wr_addr_a, 0);
      check({tag, " wr_b"},  bus.wr_addr_b, 0);
   endtask

   // j = cycles since busy rose; 6-cycle stages: 4 reads then 2 drain cycles.
   task automatic check_cycle(input logic m, input int j);
      int    base;
      int    jw;
      logic  exp_rd, exp_wr;
      int    ra, rb, rt, wa, wb;
      string t;
      base   = m ? 12 : 0;
      exp_rd = (j < 18) && ((j % 6) < 4);
      jw     = j - PIPE_LAT;
      exp_wr = (jw >= 0) && (jw < 18) && ((jw % 6) < 4);
      ra = 0; rb = 0; rt = 0; wa = 0; wb = 0;
      if (exp_rd) begin
         ra = tab[base + (j / 6) * 4 + (j % 6)].a;
         rb = tab[base + (j / 6) * 4 + (j % 6)].b;
         rt = tab[base + (j / 6) * 4 + (j % 6)].tw;
      end
      if (exp_wr) begin
         wa = tab[base + (jw / 6) * 4 + (jw % 6)].a;
         wb = tab[base + (jw / 6) * 4 + (jw % 6)].b;
      end
      t = $sformatf("m%0d j%0d", m, j);
      check({t, " busy"},  bus.busy,      (j < 18) ? 1 : 0);
      check({t, " done"},  bus.done,      (j == 18) ? 1 : 0);
      check({t, " rd_en"}, bus.rd_en,     exp_rd);
      check({t, " rd_a"},  bus.rd_addr_a, ra);
      check({t, " rd_b"},  bus.rd_addr_b, rb);
      check({t, " tw"},    bus.tw_idx,    rt);
      check({t, " wr_en"}, bus.wr_en,     exp_wr);
      check({t, " wr_a"},  bus.wr_addr_a, wa);
      check({t, " wr_b"},  bus.wr_addr_b, wb);
      if (exp_rd) begin
         check({t, " bf_s"}, bus.bf_s, tab[base + (j / 6) * 4 + (j % 6)].mode);
      end
   endtask

   // Call at a falling edge; start is taken on the next rising edge.
   task automatic run_check(input logic m, input int poke_j, input logic poke_mode);
      bus.start = 1'b1;
      bus.mode  = m;
      for (int j = 0; j < 21; j++) begin
         @(negedge clk);
         check_cycle(m, j);
         if (j == poke_j) begin
            bus.start = 1'b1;
            bus.mode  = poke_mode;
         end else begin
            bus.start = 1'b0;
         end
      end
   endtask

   initial begin
      // DIT
      set_vec(0, 1'b0, 0, 1, 0);  set_vec(1, 1'b0, 2, 3, 0);
      set_vec(2, 1'b0, 4, 5, 0);  set_vec(3, 1'b0, 6, 7, 0);
      set_vec(4, 1'b0, 0, 2, 0);  set_vec(5, 1'b0, 1, 3, 2);
      set_vec(6, 1'b0, 4, 6, 0);  set_vec(7, 1'b0, 5, 7, 2);
      set_vec(8, 1'b0, 0, 4, 0);  set_vec(9, 1'b0, 1, 5, 1);
      set_vec(10, 1'b0, 2, 6, 2); set_vec(11, 1'b0, 3, 7, 3);
      // DIF
      set_vec(12, 1'b1, 0, 4, 0); set_vec(13, 1'b1, 1, 5, 1);
      set_vec(14, 1'b1, 2, 6, 2); set_vec(15, 1'b1, 3, 7, 3);
      set_vec(16, 1'b1, 0, 2, 0); set_vec(17, 1'b1, 1, 3, 2);
      set_vec(18, 1'b1, 4, 6, 0); set_vec(19, 1'b1, 5, 7, 2);
      set_vec(20, 1'b1, 0, 1, 0); set_vec(21, 1'b1, 2, 3, 0);
      set_vec(22, 1'b1, 4, 5, 0); set_vec(23, 1'b1, 6, 7, 0);

      bus.start = 1'b0;
      bus.mode  = 1'b0;
`ifdef BFSCHED_ABORT_EN
      bus.abort = 1'b0;
`endif
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("por");

      // start on the very first rising edge after reset release
      rst = 1'b1;
      run_check(1'b0, -1, 1'b0);
      // DIF transform
      run_check(1'b1, -1, 1'b0);
      // start with flipped mode mid stage 1 must be ignored
      run_check(1'b0, 7, 1'b1);
      // start coinciding with done must be ignored
      run_check(1'b1, 18, 1'b0);

      // reset in the middle of stage 1
      bus.start = 1'b1;
      bus.mode  = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
      check("mid rd_en before rst", bus.rd_en, 1);
      rst = 1'b0;
      #1;
      check_zero("rst immediate");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_zero($sformatf("rst held %0d", i));
      end
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("post rst %0d wr_en", i), bus.wr_en, 0);
         check($sformatf("post rst %0d busy", i),  bus.busy,  0);
      end
      run_check(1'b0, -1, 1'b0);

`ifdef BFSCHED_ABORT_EN
      // abort during the stage-0 drain
      bus.start = 1'b1;
      bus.mode  = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      check("abort pre rd_en", bus.rd_en, 0);
      check("abort pre busy",  bus.busy,  1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort busy",  bus.busy,  0);
      check("abort rd_en", bus.rd_en, 0);
      check("abort wr_en", bus.wr_en, 0);
      check("abort done",  bus.done,  0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("abort after %0d wr_en", i), bus.wr_en, 0);
         check($sformatf("abort after %0d done", i),  bus.done,  0);
      end
      run_check(1'b1, -1, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
